// File: rtl/usb_rx.sv
// Full-speed USB receive path: line synchronisation, bit-timing recovery, NRZI decode,
// bit-unstuffing, SYNC/PID/EOP checking and byte assembly into the shared packet buffer.
module usb_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 4,
  parameter int BUFFER_SIZE  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic [6:0] buffer_occupancy,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error
);
  localparam int         TW       = $clog2(CLKS_PER_BIT);
  localparam logic [2:0] PID_NONE = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          dp_meta_q, dm_meta_q, dp_q, dm_q, dp_prev_q, dm_prev_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          prev_lvl_q, prev_lvl_d;
  logic [2:0]    ones_q, ones_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [6:0]    byte_cnt_q, byte_cnt_d;
  logic          eop_wait_j_q, eop_wait_j_d;
  logic          err_se0_q, err_se0_d;
  logic [3:0]    jcnt_q, jcnt_d;
  logic [7:0]    data_q, data_d;
  logic          store_q, store_d;
  logic [2:0]    packet_q, packet_d;
  logic          ready_q, ready_d;
  logic          active_q, active_d;
  logic          error_q, error_d;

  logic       sample, is_se0, is_j, nrzi_bit, start, goto_err;
  logic [7:0] byte_now;
  logic [2:0] pid_kind;

  // Maps a received PID byte to its packet type; PID_NONE marks an invalid PID.
  function automatic logic [2:0] decode_pid(input logic [7:0] pid);
    logic [2:0] kind;
    case (pid[3:0])
      4'b0001: kind = 3'd0;
      4'b1001: kind = 3'd1;
      4'b0011: kind = 3'd2;
      4'b1011: kind = 3'd3;
      4'b0010: kind = 3'd4;
      4'b1010: kind = 3'd5;
      4'b1110: kind = 3'd6;
      default: kind = PID_NONE;
    endcase
    if (pid[7:4] != ~pid[3:0]) kind = PID_NONE;
    return kind;
  endfunction

  function automatic logic len_ok(input logic [2:0] kind, input logic [6:0] n);
    case (kind)
      3'd0, 3'd1:       return n == 7'd2;
      3'd2, 3'd3:       return n <= 7'(BUFFER_SIZE);
      3'd4, 3'd5, 3'd6: return n == 7'd0;
      default:          return 1'b0;
    endcase
  endfunction

  assign sample   = (tmr_q == TW'(SAMPLE_POINT));
  assign is_se0   = !dp_q && !dm_q;
  assign is_j     = dp_q && !dm_q;
  assign nrzi_bit = (dp_q == prev_lvl_q);
  assign byte_now = {nrzi_bit, shift_q[7:1]};
  assign pid_kind = decode_pid(byte_now);
  assign start    = dp_prev_q && !dm_prev_q && !dp_q && dm_q;

  // NOTE: every variable gets a default before the case so no latches are inferred.
  always_comb begin
    state_d      = state_q;
    tmr_d        = (dp_q != dp_prev_q || tmr_q == TW'(CLKS_PER_BIT - 1)) ? '0 : tmr_q + TW'(1);
    prev_lvl_d   = prev_lvl_q;
    ones_d       = ones_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    eop_wait_j_d = eop_wait_j_q;
    err_se0_d    = (state_q == S_ERR) ? err_se0_q : 1'b0;
    jcnt_d       = (state_q == S_ERR) ? jcnt_q : 4'd0;
    data_d       = data_q;
    store_d      = 1'b0;
    packet_d     = packet_q;
    ready_d      = 1'b0;
    error_d      = error_q;
    goto_err     = 1'b0;

    unique case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_SYNC;
        prev_lvl_d = 1'b1;
        ones_d     = '0;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        error_d    = 1'b0;
      end
      S_SYNC, S_PID, S_DATA: if (sample) begin
        if (is_se0) begin
          if (state_q == S_DATA) begin
            state_d      = S_EOP;
            eop_wait_j_d = 1'b0;
          end else goto_err = 1'b1;
        end else begin
          prev_lvl_d = dp_q;
          if (ones_q == 3'd6) begin
            // Stuffed bit: must be a 0 and never reaches the shifter.
            ones_d = '0;
            if (nrzi_bit) goto_err = 1'b1;
          end else begin
            ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            shift_d   = byte_now;
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
              S_SYNC: begin
                if (nrzi_bit != (bit_cnt_q == 3'd7)) goto_err = 1'b1;
                else if (bit_cnt_q == 3'd7)        state_d  = S_PID;
              end
              S_PID: if (bit_cnt_q == 3'd7) begin
                if (pid_kind != PID_NONE) begin
                  packet_d = pid_kind;
                  state_d  = S_DATA;
                end else goto_err = 1'b1;
              end
              S_DATA: if (bit_cnt_q == 3'd7) begin
                if (buffer_occupancy == 7'(BUFFER_SIZE)) goto_err = 1'b1;
                else begin
                  store_d = 1'b1;
                  data_d  = byte_now;
                  if (byte_cnt_q != 7'h7f) byte_cnt_d = byte_cnt_q + 7'd1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      S_EOP: if (sample) begin
        if (!eop_wait_j_q) begin
          if (is_se0) eop_wait_j_d = 1'b1;
          else        goto_err     = 1'b1;
        end else if (is_j && bit_cnt_q == 3'd0 && len_ok(packet_q, byte_cnt_q)) begin
          state_d = S_DONE;
          ready_d = 1'b1;
        end else goto_err = 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: if (sample) begin
        if (is_se0) begin
          err_se0_d = 1'b1;
          jcnt_d    = '0;
        end else if (is_j) begin
          if (err_se0_q || jcnt_q == 4'd15) state_d = S_IDLE;
          else                              jcnt_d  = jcnt_q + 4'd1;
        end else jcnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (goto_err) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end
    active_d = (state_d == S_SYNC) || (state_d == S_PID) || (state_d == S_DATA) || (state_d == S_EOP);
  end

  // NOTE: the two-flop synchroniser idles at J so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      {dp_meta_q, dp_q, dp_prev_q} <= 3'b111;
      {dm_meta_q, dm_q, dm_prev_q} <= 3'b000;
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      prev_lvl_q   <= 1'b1;
      ones_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      eop_wait_j_q <= 1'b0;
      err_se0_q    <= 1'b0;
      jcnt_q       <= '0;
      data_q       <= '0;
      store_q      <= 1'b0;
      packet_q     <= PID_NONE;
      ready_q      <= 1'b0;
      active_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      {dp_prev_q, dp_q, dp_meta_q} <= {dp_q, dp_meta_q, dp_in};
      {dm_prev_q, dm_q, dm_meta_q} <= {dm_q, dm_meta_q, dm_in};
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      prev_lvl_q   <= prev_lvl_d;
      ones_q       <= ones_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      eop_wait_j_q <= eop_wait_j_d;
      err_se0_q    <= err_se0_d;
      jcnt_q       <= jcnt_d;
      data_q       <= data_d;
      store_q      <= store_d;
      packet_q     <= packet_d;
      ready_q      <= ready_d;
      active_q     <= active_d;
      error_q      <= error_d;
    end
  end

  assign rx_packet_data       = data_q;
  assign store_rx_packet_data = store_q;
  assign rx_packet            = packet_q;
  assign rx_data_ready        = ready_q;
  assign rx_transfer_active   = active_q;
  assign rx_error             = error_q;
endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx: encodes packets onto D+/D- (stuffing, NRZI, EOP) and
// compares the receiver's outputs against hand-computed values.
module tb_usb_rx;
  localparam int BIT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp_in, dm_in;
  logic [6:0] buffer_occupancy;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic [2:0] rx_packet;
  logic       rx_data_ready, rx_transfer_active, rx_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int ready_cnt, ready_run, ready_max, ready_cyc, j_cyc;

  usb_rx dut (
    .clk                  (clk),
    .rst                  (rst),
    .dp_in                (dp_in),
    .dm_in                (dm_in),
    .buffer_occupancy     (buffer_occupancy),
    .rx_packet_data       (rx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (store_rx_packet_data) got.push_back(rx_packet_data);
    if (rx_data_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
      ready_run++;
      if (ready_run > ready_max) ready_max = ready_run;
    end else ready_run = 0;
  end

  task automatic clear_mon();
    got.delete();
    ready_cnt = 0; ready_run = 0; ready_max = 0; ready_cyc = -1;
  endtask

  task automatic drive_line(input logic dp, input logic dm, input int bits);
    dp_in = dp;
    dm_in = dm;
    repeat (bits * BIT) @(negedge clk);
  endtask

  // SYNC + PID + payload, stuffed and NRZI encoded, then SE0 SE0 J. abort_at < 0 sends all.
  task automatic send_packet(input logic [7:0] pid, input int nbytes,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input bit corrupt, input int abort_at);
    bit raw[$];
    bit st[$];
    logic [7:0] bytes [3];
    int ones, first_stuff;
    logic lvl;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
    for (int k = 0; k < nbytes; k++)
      for (int i = 0; i < 8; i++) raw.push_back(bytes[k][i]);
    ones = 0;
    first_stuff = -1;
    foreach (raw[i]) begin
      st.push_back(raw[i]);
      if (raw[i]) ones++; else ones = 0;
      if (ones == 6) begin
        if (first_stuff < 0) first_stuff = st.size();
        st.push_back(1'b0);
        ones = 0;
      end
    end
    if (corrupt && first_stuff >= 0) st[first_stuff] = 1'b1;
    lvl = 1'b1;
    foreach (st[i]) begin
      if (i == abort_at) return;
      if (!st[i]) lvl = ~lvl;
      drive_line(lvl, ~lvl, 1);
    end
    drive_line(1'b0, 1'b0, 2);
    j_cyc = cyc;
    drive_line(1'b1, 1'b0, 1);
    drive_line(1'b1, 1'b0, 4);
  endtask

  task automatic test_reset();
    rst = 1'b1; dp_in = 1'b1; dm_in = 1'b0; buffer_occupancy = 7'd0;
    repeat (4) @(negedge clk);
    checks++; if (rx_packet !== 3'd7) begin errors++; $display("FAIL reset_pid: got %0d expected 7", rx_packet); end
    checks++; if ({store_rx_packet_data, rx_data_ready, rx_transfer_active, rx_error} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {store_rx_packet_data, rx_data_ready, rx_transfer_active, rx_error}); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ack();
    clear_mon();
    send_packet(8'hD2, 0, 8'h00, 8'h00, 8'h00, 1'b0, -1);
    checks++; if (rx_packet !== 3'd4) begin errors++; $display("FAIL ack_pid: got %0d expected 4", rx_packet); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL ack_strobes: got %0d expected 0", got.size()); end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL ack_ready: got %0d pulses expected 1", ready_cnt); end
    checks++; if (ready_max != 1) begin errors++; $display("FAIL ack_ready_width: got %0d expected 1", ready_max); end
    checks++; if (ready_cyc - j_cyc != 8) begin errors++; $display("FAIL ack_ready_delay: got %0d expected 8", ready_cyc - j_cyc); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL ack_error: got %b expected 0", rx_error); end
    checks++; if (rx_transfer_active !== 1'b0) begin errors++; $display("FAIL ack_active: got %b expected 0", rx_transfer_active); end
  endtask

  task automatic test_data0();
    logic [7:0] exp [3];
    exp[0] = 8'h59; exp[1] = 8'h5A; exp[2] = 8'h5B;
    clear_mon();
    send_packet(8'hC3, 3, 8'h59, 8'h5A, 8'h5B, 1'b0, -1);
    checks++; if (rx_packet !== 3'd2) begin errors++; $display("FAIL d0_pid: got %0d expected 2", rx_packet); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL d0_strobes: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        errors++; $display("FAIL d0_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
    end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL d0_ready: got %0d expected 1", ready_cnt); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL d0_error: got %b expected 0", rx_error); end
  endtask

  task automatic test_stuffing();
    clear_mon();
    send_packet(8'h4B, 3, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1);
    checks++; if (rx_packet !== 3'd3) begin errors++; $display("FAIL d1_pid: got %0d expected 3", rx_packet); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL d1_strobes: got %0d expected 3", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== 8'hFF) begin errors++; $display("FAIL d1_byte%0d: got %h expected ff", i, got[i]); end
    end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL d1_ready: got %0d expected 1", ready_cnt); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL d1_error: got %b expected 0", rx_error); end
    clear_mon();
    send_packet(8'h4B, 3, 8'hFF, 8'hFF, 8'hFF, 1'b1, -1);
    checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL stuff_err: got %b expected 1", rx_error); end
    checks++; if (ready_cnt != 0) begin errors++; $display("FAIL stuff_ready: got %0d expected 0", ready_cnt); end
  endtask

  task automatic test_bad_pid();
    clear_mon();
    send_packet(8'hC2, 0, 8'h00, 8'h00, 8'h00, 1'b0, -1);
    checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL badpid_err: got %b expected 1", rx_error); end
    checks++; if (rx_packet !== 3'd3) begin errors++; $display("FAIL badpid_pid: got %0d expected 3", rx_packet); end
    checks++; if (ready_cnt != 0) begin errors++; $display("FAIL badpid_ready: got %0d expected 0", ready_cnt); end
    checks++; if (rx_transfer_active !== 1'b0) begin errors++; $display("FAIL badpid_active: got %b expected 0", rx_transfer_active); end
  endtask

  task automatic test_overflow();
    clear_mon();
    buffer_occupancy = 7'd64;
    send_packet(8'hC3, 2, 8'h01, 8'h02, 8'h00, 1'b0, -1);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL ovf_strobes: got %0d expected 0", got.size()); end
    checks++; if (rx_error !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b expected 1", rx_error); end
    checks++; if (ready_cnt != 0) begin errors++; $display("FAIL ovf_ready: got %0d expected 0", ready_cnt); end
    buffer_occupancy = 7'd0;
    clear_mon();
    send_packet(8'hD2, 0, 8'h00, 8'h00, 8'h00, 1'b0, -1);
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL ovf_ack_err: got %b expected 0", rx_error); end
    checks++; if (rx_packet !== 3'd4) begin errors++; $display("FAIL ovf_ack_pid: got %0d expected 4", rx_packet); end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL ovf_ack_ready: got %0d expected 1", ready_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    clear_mon();
    send_packet(8'hC3, 3, 8'h59, 8'h5A, 8'h5B, 1'b0, 28);
    checks++; if (rx_transfer_active !== 1'b1) begin errors++; $display("FAIL mid_active: got %b expected 1", rx_transfer_active); end
    checks++; if (rx_packet !== 3'd2) begin errors++; $display("FAIL mid_pid: got %0d expected 2", rx_packet); end
    rst = 1'b1; dp_in = 1'b1; dm_in = 1'b0;
    @(negedge clk);
    checks++; if (rx_packet !== 3'd7) begin errors++; $display("FAIL rst_pid: got %0d expected 7", rx_packet); end
    checks++; if (rx_packet_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", rx_packet_data); end
    checks++; if ({store_rx_packet_data, rx_data_ready, rx_transfer_active, rx_error} !== 4'b0000) begin
      errors++; $display("FAIL rst_flags: got %b expected 0000",
                         {store_rx_packet_data, rx_data_ready, rx_transfer_active, rx_error}); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    clear_mon();
    send_packet(8'h5A, 0, 8'h00, 8'h00, 8'h00, 1'b0, -1);
    checks++; if (rx_packet !== 3'd5) begin errors++; $display("FAIL nak_pid: got %0d expected 5", rx_packet); end
    checks++; if (ready_cnt != 1) begin errors++; $display("FAIL nak_ready: got %0d expected 1", ready_cnt); end
    checks++; if (rx_error !== 1'b0) begin errors++; $display("FAIL nak_error: got %b expected 0", rx_error); end
  endtask

  initial begin
    clear_mon();
    @(negedge clk);
    test_reset();
    test_ack();
    test_data0();
    test_stuffing();
    test_bad_pid();
    test_overflow();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_rx.md
Name: usb_rx

Overview:
- Full-speed USB 1.0 serial receiver; the receive-side counterpart of usb_tx.
- Samples the D+/D- line pair and recovers bit timing from line edges.
- Performs NRZI decode, bit-unstuffing, SYNC/PID/EOP detection and byte assembly.
- Pushes received payload bytes into the shared packet buffer and reports packet type, completion and errors to the protocol FSM.

Parameters:
CLKS_PER_BIT, 8, nominal system clocks per bit (100 MHz clk / 12 Mbps, truncated); bit timer resyncs on every line edge.
SAMPLE_POINT, 4, bit-timer count at which the line is sampled.
BUFFER_SIZE, 64, buffer capacity in bytes; overflow threshold.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
dp_in  input  1  D+ line, asynchronous to clk
dm_in  input  1  D- line, asynchronous to clk
buffer_occupancy  input  7  current bytes held in packet buffer
rx_packet_data  output  8  received byte, valid while store_rx_packet_data is high
store_rx_packet_data  output  1  one-cycle write strobe to buffer
rx_packet  output  3  PID type: OUT=0 IN=1 DATA0=2 DATA1=3 ACK=4 NAK=5 STALL=6 NONE=7
rx_data_ready  output  1  one-cycle pulse, packet received without error
rx_transfer_active  output  1  high while a packet is being received
rx_error  output  1  sticky error flag

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high. On rst: state IDLE, rx_packet=7, all other outputs 0, counters cleared. An assertion of rst mid-packet abandons that packet; any residual line activity is treated as a new start and normally ends in a SYNC error.
- Input synchronisation: dp_in and dm_in pass through 2-flop synchronisers. All timing refers to the synchronised values (2-cycle input latency).
- Line states: J = (dp=1, dm=0); K = (dp=0, dm=1); SE0 = (0, 0).
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Forced to 0 on any change of the synchronised dp.
  - Line is sampled when the count equals SAMPLE_POINT.
- NRZI decode: sampled level equal to previous sampled level → 1; change → 0. The previous level is initialised to J at start-of-packet.
- Unstuffing:
  - A ones counter runs from the first SYNC bit onward.
  - After six consecutive 1s, the next bit must be 0; it is discarded and the counter cleared.
  - If that bit is 1 → stuff error.
- States:
  - IDLE: wait for a J→K transition. Then timer=0, rx_transfer_active=1, rx_error cleared, → SYNC.
  - SYNC: 8 decoded bits must be 0000000 then 1, in transmission order. Otherwise → ERR.
  - PID: 8 bits, LSB first. Valid iff pid[7:4]==~pid[3:0] and pid[3:0] is one of 0001 OUT, 1001 IN, 0011 DATA0, 1011 DATA1, 0010 ACK, 1010 NAK, 1110 STALL. On valid, rx_packet is updated the cycle after the 8th PID bit and holds until the next valid PID. Invalid → ERR.
  - DATA: assembles bytes LSB first. The cycle after each 8th bit sample, store_rx_packet_data=1 for exactly 1 cycle with rx_packet_data=byte. If buffer_occupancy==BUFFER_SIZE at that point → no strobe, ERR. Sampling SE0 → EOP.
  - EOP: requires SE0 for 2 bit samples, then J at the next sample. Also requires a partial bit count of 0 and a byte count of 0 for ACK/NAK/STALL, 2 for OUT/IN, and 0..64 for DATA0/1 (CRC bytes are forwarded, not checked). Pass → DONE; any failure → ERR.
  - DONE: rx_data_ready=1 for 1 cycle, rx_transfer_active=0, → IDLE.
  - ERR: rx_error=1, rx_transfer_active=0. Waits for SE0-then-J or 16 consecutive J samples, → IDLE. rx_error holds until the next start-of-packet.
- An SE0 in SYNC or PID, or a K/J sampled inside EOP, → ERR.
- Simultaneous start edge and rst: rst wins.

Test Plan:
- ACK (K-J SYNC, PID 11010010, SE0 SE0 J) → rx_packet=4, no store strobes, rx_data_ready pulse 1 cycle after EOP J, rx_error=0.
- DATA0 with bytes 59,5A,5B, occupancy 0 → PID 11000011, rx_packet=2, three strobes with data 59/5A/5B in order, rx_data_ready=1.
- DATA1 with three bytes FF, including stuffed zeros → three strobes of FF, no error. Same stream with one stuffed zero replaced by 1 → rx_error=1, rx_data_ready never asserted.
- Bad PID 11000010 (complement mismatch) → rx_error=1, rx_packet unchanged, returns to IDLE after SE0/J.
- DATA0 of 2 bytes with buffer_occupancy=64 → no strobe, rx_error=1. A following good ACK clears rx_error and gives rx_packet=4.
- rst asserted mid-DATA0 → next cycle all outputs at reset values, rx_packet=7. A subsequent clean NAK → rx_packet=5, rx_data_ready pulse.
